sort_controller: RTL

SORT_CONTROLLER -- requirements
Module: sort_controller

---
 rtl/sort_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/sort_controller.sv
// sort_controller: sequencing FSM for an insertion-style sorting cell array.
// It loads a batch of words into the array, then unloads them smallest-first
// from the head cell, and finally clears the array for the next batch.
// Optional build macro: SORT_CTRL_DESCENDING_EN complements the words on the
// way in and out, so the same ascending array yields descending output.
module sort_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CELLS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  array_enable,
  output logic                  array_shift_up,
  output logic [DATA_WIDTH-1:0] array_new_data,
  output logic                  array_clear,
  input  logic [DATA_WIDTH-1:0] head_data,
  output logic                  busy
);

  localparam int CW = $clog2(NUM_CELLS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_CELLS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UNLOAD = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            accepting;
  logic            in_xfer;
  logic            out_xfer;
  logic [DATA_WIDTH-1:0] in_word;
  logic [DATA_WIDTH-1:0] head_word;

`ifdef SORT_CTRL_DESCENDING_EN
  assign in_word   = ~in_data;
  assign head_word = ~head_data;
`else
  assign in_word   = in_data;
  assign head_word = head_data;
`endif

  // Handshakes and array commands decoded from the current state; reset masks
  // every output except the clear line, which is held high while reset is.
  always_comb begin
    accepting      = ~reset && ((state == IDLE) || (state == LOAD)) && (count < FULL);
    in_ready       = accepting;
    in_xfer        = in_valid && accepting;
    out_valid      = (state == UNLOAD);
    out_xfer       = out_valid && out_ready;
    out_last       = out_valid && (count == ONE);
    out_data       = out_valid ? head_word : '0;
    array_enable   = in_xfer || out_xfer;
    array_shift_up = out_xfer;
    array_new_data = in_xfer ? in_word : '0;
    array_clear    = reset || (state == CLEAR);
    busy           = (state != IDLE);
  end

  // Batch sequencing and occupancy tracking; the count mirrors how many cells
  // of the array currently hold a word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (in_xfer) begin
            count <= count + ONE;
            if (in_last || (count == FULL - ONE)) begin
              state <= UNLOAD;
            end else begin
              state <= LOAD;
            end
          end
        end
        UNLOAD: begin
          if (out_xfer) begin
            count <= count - ONE;
            if (count == ONE) begin
              state <= CLEAR;
            end
          end
        end
        CLEAR: begin
          count <= '0;
          state <= IDLE;
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
